ecc_secded_pipe: RTL
====================

# ecc_secded_pipe

Parametrised, pipelined single-error-correct/double-error-detect (SEC-DED) decoder, successor to the combinational 32-bit single-error-correcting benchmark circuit. It takes a data word plus extended-Hamming check bits, corrects any single-bit error, flags double errors, and keeps saturating error statistics. It sits at the timing-benchmark boundary behind a valid/ready stream and generalises width, adds an overall-parity (DED) bit and a two-stage register pipeline.

## Interface
- DATA_W, 32: data bits per word (4..64).
- CNT_W, 16: width of each error counter.
- P (derived, not overridable): smallest integer with 2^P >= DATA_W+P+1; CHK_W = P+1 (7 for DATA_W=32).
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- chk_en  in  1  check enable, sampled with the word; 0 = bypass correction.
- in_valid  in  1  input word valid.
- in_ready  out  1  block accepts the input word this cycle.
- in_data  in  DATA_W  received data.
- in_chk  in  CHK_W  received check bits; bit P is overall parity.
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer accepts the output word.
- out_data  out  DATA_W  corrected data.
- out_status  out  2  00 clean, 01 corrected data bit, 10 corrected check bit, 11 uncorrectable.
- out_syn  out  P  syndrome of the output word.
- clr_cnt  in  1  synchronous clear of both counters.
- ce_cnt  out  CNT_W  corrected-error count.
- ue_cnt  out  CNT_W  uncorrectable count.

## Operation
- Code positions 1..DATA_W+P; check bit i sits at position 2^i; data bits fill the remaining positions in ascending order (data[0] at position 3).
- Check bit i = XOR of data bits whose position has bit i set; chk[P] = XOR of all data and chk[P-1:0].
- Stage 1 computes syndrome s = recomputed XOR received (P bits) and q = overall parity mismatch; registers data, s, q, chk_en.
- Stage 2 classifies: s=0,q=0 → 00; q=1,s=0 → 10 (parity bit); q=1, s a power of two → 10; q=1, s maps to a data position → flip that bit, 01; q=1, s > DATA_W+P → 11; q=0,s≠0 → 11.
- Status 11: data passed uncorrected.
- chk_en=0: data passed unmodified, status 00, out_syn 0, no counting.
- Counters increment on output handshake (out_valid & out_ready): status 01/10 → ce_cnt, 11 → ue_cnt; saturate at all-ones.
- clr_cnt together with an increment: clear wins, counter = 0.

## Timing
- Reset values: out_valid 0, out_data 0, out_status 00, out_syn 0, ce_cnt 0, ue_cnt 0, both stage-valid flags 0; in_ready 1 one cycle after reset release.
- Latency 2 cycles, input handshake to out_valid, with no stall; throughput 1 word/cycle.
- Stage 2 advances when !out_valid or out_ready; stage 1 advances when stage 2 advances or is empty; in_ready = !s1_valid or s1 advances (combinational from out_ready).
- out_data/out_status/out_syn held stable while out_valid & !out_ready.
- Reset asserted mid-stream: all in-flight words discarded, counters cleared, no output handshake on the reset edge.

## Configuration
- ECC_ERR_LOG_EN defined: ce_cnt, ue_cnt and out_syn are live as described; clr_cnt is honoured.
- Undefined: counter and syndrome-output registers are not built; ce_cnt, ue_cnt and out_syn are tied to 0; clr_cnt is ignored; correction and status are unchanged.

## Structure
- Package ecc_secded_pkg holds:
  - function chk_bits(DATA_W) returning P;
  - function data_pos(idx) giving the code position of data bit idx;
  - the status enum (CLEAN, CE_DATA, CE_CHK, UE).
- One sub-module, ecc_syndrome_gen: combinational, parametrised by DATA_W; produces the P recomputed check bits and the overall parity. It is reused by the bench as the reference encoder.

## Test plan
- Encode 0xDEADBEEF, chk_en=1, out_ready=1 → out_data 0xDEADBEEF, status 00, out_valid exactly 2 cycles after accept.
- Same word with data[0] flipped → syndrome 3, out_data 0xDEADBEEF, status 01, ce_cnt 1.
- Flip in_chk[6] (overall parity) → status 10; flip data[0] and data[1] → status 11, data unchanged, ue_cnt 1.
- Stream 8 words, out_ready toggling 1/0 each cycle → all 8 words out in order, none duplicated, outputs stable while stalled.
- CNT_W=4, 20 single-error words → ce_cnt saturates at 15; clr_cnt on the same cycle as a CE handshake → ce_cnt 0.
- chk_en=0 with data[5] flipped → data passes flipped, status 00, counters unchanged; rst asserted with 2 words in flight → out_valid 0, counters 0.

Source files
------------

// File: rtl/ecc_secded_pkg.sv
`default_nettype none
// =============================================================================
// Module   : ecc_secded_pkg
// Brief    : Shared types and elaboration helpers for the SEC-DED decoder.
// Revision : 1.0  initial release
// =============================================================================
package ecc_secded_pkg;

    typedef enum logic [1:0] {
        CLEAN   = 2'b00,
        CE_DATA = 2'b01,
        CE_CHK  = 2'b10,
        UE      = 2'b11
    } ecc_status_e;

    // Smallest P with 2^P >= data_w + P + 1.
    function automatic int chk_bits(input int data_w);
        int p;
        p = 0;
        for (int k = 1; k <= 8; k++) begin
            if (p == 0 && (1 << k) >= data_w + k + 1) begin
                p = k;
            end
        end
        return p;
    endfunction

    // Code position of data bit idx: positions skip every power of two.
    function automatic int data_pos(input int idx);
        int p;
        int n;
        p = 0;
        n = 0;
        for (int k = 3; k < 128; k++) begin
            if ((k & (k - 1)) != 0) begin
                if (n == idx && p == 0) begin
                    p = k;
                end
                n++;
            end
        end
        return p;
    endfunction

    // Data bits covered by check bit bit_i.
    function automatic logic [63:0] chk_mask(input int data_w, input int bit_i);
        logic [63:0] m;
        m = '0;
        for (int j = 0; j < 64; j++) begin
            if (j < data_w && ((data_pos(j) >> bit_i) & 1) != 0) begin
                m[j] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ecc_secded_pipe_if.sv
`default_nettype none
// =============================================================================
// Module   : ecc_secded_pipe_if
// Brief    : Input and output valid/ready streams of the SEC-DED decoder.
// Revision : 1.0  initial release
// =============================================================================
interface ecc_secded_pipe_if #(
    parameter int DATA_W = 32
);
    import ecc_secded_pkg::*;

    localparam int c_p = chk_bits(DATA_W);

    logic              chk_en;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [c_p:0]      in_chk;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        out_status;
    logic [c_p-1:0]    out_syn;

    modport master (
        output chk_en, in_valid, in_data, in_chk, out_ready,
        input  in_ready, out_valid, out_data, out_status, out_syn
    );

    modport slave (
        input  chk_en, in_valid, in_data, in_chk, out_ready,
        output in_ready, out_valid, out_data, out_status, out_syn
    );

endinterface
`default_nettype wire

// File: rtl/ecc_syndrome_gen.sv
`default_nettype none
// =============================================================================
// Module   : ecc_syndrome_gen
// Brief    : Combinational Hamming check-bit and overall-parity generator.
// Revision : 1.0  initial release
// =============================================================================
module ecc_syndrome_gen
    import ecc_secded_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int c_p    = chk_bits(DATA_W)
) (
    input  wire logic [DATA_W-1:0] i_data,
    output logic      [c_p-1:0]    o_chk,
    output logic                   o_par
);

    generate
        for (genvar i = 0; i < c_p; i++) begin : g_chk
            localparam logic [63:0] c_mask = chk_mask(DATA_W, i);
            assign o_chk[i] = ^(i_data & c_mask[DATA_W-1:0]);
        end
    endgenerate

    // Overall parity of the encoded word excluding the parity bit itself.
    assign o_par = (^i_data) ^ (^o_chk);

endmodule
`default_nettype wire

// File: rtl/ecc_secded_pipe.sv
`default_nettype none
// =============================================================================
// Module   : ecc_secded_pipe
// Brief    : Two-stage pipelined SEC-DED decoder with valid/ready streams.
//            Optional ECC_ERR_LOG_EN builds syndrome output and error counters.
// Revision : 1.0  initial release
// =============================================================================
module ecc_secded_pipe
    import ecc_secded_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    ecc_secded_pipe_if.slave      bus,
    input  wire logic             clr_cnt,
    output logic      [CNT_W-1:0] ce_cnt,
    output logic      [CNT_W-1:0] ue_cnt
);

    localparam int              c_p     = chk_bits(DATA_W);
    localparam logic [31:0]     c_n_pos = 32'(DATA_W + c_p);
    localparam logic [c_p-1:0]  c_one   = 1;

    logic [c_p-1:0]    w_gen_chk;
    logic              w_gen_par;
    logic [c_p-1:0]    w_syn;
    logic              w_q;
    logic              w_s2_adv;
    logic              w_s1_adv;
    logic              w_in_ready;
    logic [DATA_W-1:0] w_flip;
    logic              w_pow2;
    logic [31:0]       w_syn_ext;
    ecc_status_e       w_s2_status;

    logic              r_s1_valid;
    logic [DATA_W-1:0] r_s1_data;
    logic [c_p-1:0]    r_s1_syn;
    logic              r_s1_q;
    logic              r_s1_en;

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    ecc_status_e       r_out_status;

    // ---------------------------------------------------------------- stage 1
    ecc_syndrome_gen #(
        .DATA_W (DATA_W)
    ) u_syn_gen (
        .i_data (bus.in_data),
        .o_chk  (w_gen_chk),
        .o_par  (w_gen_par)
    );

    // q reduces to the parity of the whole received codeword.
    assign w_syn = w_gen_chk ^ bus.in_chk[c_p-1:0];
    assign w_q   = w_gen_par ^ bus.in_chk[c_p] ^ (^w_syn);

    assign w_s2_adv   = !r_out_valid || bus.out_ready;
    assign w_s1_adv   = w_s2_adv;
    assign w_in_ready = !r_s1_valid || w_s1_adv;
    assign bus.in_ready = w_in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_syn   <= '0;
            r_s1_q     <= 1'b0;
            r_s1_en    <= 1'b0;
        end else if (w_in_ready) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_data <= bus.in_data;
                r_s1_syn  <= w_syn;
                r_s1_q    <= w_q;
                r_s1_en   <= bus.chk_en;
            end
        end
    end

    // ---------------------------------------------------------------- stage 2
    generate
        for (genvar j = 0; j < DATA_W; j++) begin : g_flip
            localparam int             c_pos_i = data_pos(j);
            localparam logic [c_p-1:0] c_pos   = c_pos_i[c_p-1:0];
            assign w_flip[j] = r_s1_en && r_s1_q && (r_s1_syn == c_pos);
        end
    endgenerate

    assign w_pow2    = ((r_s1_syn & (r_s1_syn - c_one)) == '0);
    assign w_syn_ext = {{(32 - c_p){1'b0}}, r_s1_syn};

    always_comb begin
        w_s2_status = CLEAN;
        if (r_s1_en) begin
            if (r_s1_syn == '0) begin
                w_s2_status = r_s1_q ? CE_CHK : CLEAN;
            end else if (!r_s1_q) begin
                w_s2_status = UE;
            end else if (w_pow2) begin
                w_s2_status = CE_CHK;
            end else if (w_syn_ext > c_n_pos) begin
                w_s2_status = UE;
            end else begin
                w_s2_status = CE_DATA;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_status <= CLEAN;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data   <= r_s1_data ^ w_flip;
                r_out_status <= w_s2_status;
            end
        end
    end

    assign bus.out_valid  = r_out_valid;
    assign bus.out_data   = r_out_data;
    assign bus.out_status = r_out_status;

    // ------------------------------------------------------ error statistics
`ifdef ECC_ERR_LOG_EN
    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [CNT_W-1:0] c_cnt_one = 1;

    logic             w_out_hs;
    logic [c_p-1:0]   r_out_syn;
    logic [CNT_W-1:0] r_ce_cnt;
    logic [CNT_W-1:0] r_ue_cnt;

    assign w_out_hs = r_out_valid && bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_syn <= '0;
        end else if (w_s2_adv && r_s1_valid) begin
            r_out_syn <= r_s1_en ? r_s1_syn : '0;
        end
    end

    // Clear has priority over a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ce_cnt <= '0;
            r_ue_cnt <= '0;
        end else if (clr_cnt) begin
            r_ce_cnt <= '0;
            r_ue_cnt <= '0;
        end else if (w_out_hs) begin
            if ((r_out_status == CE_DATA || r_out_status == CE_CHK) && r_ce_cnt != c_cnt_max) begin
                r_ce_cnt <= r_ce_cnt + c_cnt_one;
            end
            if (r_out_status == UE && r_ue_cnt != c_cnt_max) begin
                r_ue_cnt <= r_ue_cnt + c_cnt_one;
            end
        end
    end

    assign bus.out_syn = r_out_syn;
    assign ce_cnt      = r_ce_cnt;
    assign ue_cnt      = r_ue_cnt;
`else
    logic w_unused_clr;

    assign w_unused_clr = clr_cnt;
    assign bus.out_syn  = '0;
    assign ce_cnt       = '0;
    assign ue_cnt       = '0;
`endif

endmodule
`default_nettype wire
